alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters. A request
//               is granted in IDLE, its operands and opcode are latched and
//               driven to the ALU. The result is captured in EXEC and held for
//               the owner in RESP until that owner takes it.
//               Optional feature macro: ALU_ARB_ROUND_ROBIN_EN. When it is
//               defined, simultaneous requests alternate. When it is not
//               defined, requester 0 wins every tie.
// Ports       : clk, reset                 - clock, async active-high reset
//               reqN_valid/ready           - request handshake (N = 0,1)
//               reqN_SrcA/SrcB/Operation   - request operands and opcode
//               respN_valid/ready/data     - response handshake and result
//               alu_SrcA/SrcB/Operation    - latched operands to shared ALU
//               alu_ALUResult              - combinational ALU result
//               busy                       - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_SrcA,
  input  logic [DATA_WIDTH-1:0]    req0_SrcB,
  input  logic [OPCODE_LENGTH-1:0] req0_Operation,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_SrcA,
  input  logic [DATA_WIDTH-1:0]    req1_SrcB,
  input  logic [OPCODE_LENGTH-1:0] req1_Operation,
  output logic                     resp0_valid,
  input  logic                     resp0_ready,
  output logic [DATA_WIDTH-1:0]    resp0_data,
  output logic                     resp1_valid,
  input  logic                     resp1_ready,
  output logic [DATA_WIDTH-1:0]    resp1_data,
  output logic [DATA_WIDTH-1:0]    alu_SrcA,
  output logic [DATA_WIDTH-1:0]    alu_SrcB,
  output logic [OPCODE_LENGTH-1:0] alu_Operation,
  input  logic [DATA_WIDTH-1:0]    alu_ALUResult,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_srca;
  logic [DATA_WIDTH-1:0]    r_srcb;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [DATA_WIDTH-1:0]    r_result;
  logic                     r_owner;
  logic                     r_resp0_valid;
  logic                     r_resp1_valid;
  logic                     r_busy;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  // 1 means requester 1 wins the next tie.
  logic                     r_prio;
`endif

  logic w_grant0;
  logic w_grant1;
  logic w_resp_done;

  // Grants are combinational from valid so the handshake completes in the
  // same cycle. Gating with reset keeps both readys low while reset is held,
  // because the async reset already forces the state to IDLE.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == S_IDLE && !reset) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
        w_grant0 = ~r_prio;
        w_grant1 = r_prio;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
`else
      w_grant0 = req0_valid;
      w_grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

  // The response valids are registered, so a ready seen while the
  // corresponding valid is low has no effect.
  assign w_resp_done = (r_resp0_valid & resp0_ready) | (r_resp1_valid & resp1_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_srca        <= '0;
      r_srcb        <= '0;
      r_op          <= '0;
      r_result      <= '0;
      r_owner       <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_busy        <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      r_prio        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_srca  <= w_grant1 ? req1_SrcA      : req0_SrcA;
            r_srcb  <= w_grant1 ? req1_SrcB      : req0_SrcB;
            r_op    <= w_grant1 ? req1_Operation : req0_Operation;
            r_owner <= w_grant1;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            // Whoever was just served loses the next tie.
            r_prio  <= w_grant0;
`endif
          end
        end
        S_EXEC: begin
          r_result      <= alu_ALUResult;
          r_resp0_valid <= ~r_owner;
          r_resp1_valid <= r_owner;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          // Returning to IDLE means a new grant is possible at the earliest
          // one cycle after the response completes.
          if (w_resp_done) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_resp0_valid <= 1'b0;
          r_resp1_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready    = w_grant0;
  assign req1_ready    = w_grant1;
  assign resp0_valid   = r_resp0_valid;
  assign resp1_valid   = r_resp1_valid;
  assign resp0_data    = r_result;
  assign resp1_data    = r_result;
  assign alu_SrcA      = r_srca;
  assign alu_SrcB      = r_srcb;
  assign alu_Operation = r_op;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter. Drivers push the expected
//               result when a request is granted. A negedge monitor predicts
//               ready/valid/busy from the arbitration and latency rules and
//               pops the expected result on every response handshake.
//               The bench honours ALU_ARB_ROUND_ROBIN_EN in the same way as
//               the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          v   [2];
  logic [DW-1:0] sa  [2];
  logic [DW-1:0] sb  [2];
  logic [OW-1:0] sop [2];
  logic          rrdy[2];
  logic          frdy[2];
  bit            rmode = 1'b0;

  logic          req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [DW-1:0] resp0_data, resp1_data, alu_SrcA, alu_SrcB, alu_ALUResult;
  logic [OW-1:0] alu_Operation;

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_SrcA(sa[0]), .req0_SrcB(sb[0]),
    .req0_Operation(sop[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_SrcA(sa[1]), .req1_SrcB(sb[1]),
    .req1_Operation(sop[1]),
    .resp0_valid(resp0_valid), .resp0_ready(rrdy[0]), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(rrdy[1]), .resp1_data(resp1_data),
    .alu_SrcA(alu_SrcA), .alu_SrcB(alu_SrcB), .alu_Operation(alu_Operation),
    .alu_ALUResult(alu_ALUResult), .busy(busy)
  );

  // Shared ALU in the environment. Codes it does not know produce a mix of
  // the operands and the opcode, which shows whether the code passed through
  // unchanged.
  function automatic logic [DW-1:0] env_alu(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
    endcase
  endfunction
  assign alu_ALUResult = env_alu(alu_Operation, alu_SrcA, alu_SrcB);

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and reference-model state.
  logic [DW-1:0] expq0[$];
  logic [DW-1:0] expq1[$];
  int            gq[$];
  bit            m_busy = 1'b0;
  int            m_owner = 0;
  int            m_gcyc = 0;
  int            m_last = 1;
  int            cyc = 0;

  // Response-ready driver: random or fixed, changed just after each posedge.
  initial begin
    rrdy[0] = 1'b1;
    rrdy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode) begin
        rrdy[0] = ($urandom % 3) != 0;
        rrdy[1] = ($urandom % 3) != 0;
      end else begin
        rrdy[0] = frdy[0];
        rrdy[1] = frdy[1];
      end
    end
  end

  // Monitor: rules are one operation in flight, grant only when free, result
  // visible two cycles after grant, free again once the owner takes it.
  always @(negedge clk) begin : mon
    int   win;
    logic e0, e1;
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1;
      expq0.delete();
      expq1.delete();
    end else begin
      cyc++;
      e0  = 1'b0;
      e1  = 1'b0;
      win = 0;
      if (!m_busy && (v[0] || v[1])) begin
        if (v[0] && v[1]) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
          win = (m_last == 0) ? 1 : 0;
`else
          win = 0;
`endif
        end else begin
          win = v[0] ? 0 : 1;
        end
        e0 = (win == 0);
        e1 = (win == 1);
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy", busy, m_busy);
      chk("resp0_valid", resp0_valid, m_busy && m_owner == 0 && cyc >= m_gcyc + 2);
      chk("resp1_valid", resp1_valid, m_busy && m_owner == 1 && cyc >= m_gcyc + 2);
      if (resp0_valid) begin
        if (expq0.size() == 0) chk("resp0_unexpected", resp0_valid, 1'b0);
        else begin
          chk("resp0_data", resp0_data, expq0[0]);
          if (rrdy[0]) begin
            void'(expq0.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      if (resp1_valid) begin
        if (expq1.size() == 0) chk("resp1_unexpected", resp1_valid, 1'b0);
        else begin
          chk("resp1_data", resp1_data, expq1[0]);
          if (rrdy[1]) begin
            void'(expq1.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      if (e0 || e1) begin
        m_busy  = 1'b1;
        m_owner = win;
        m_gcyc  = cyc;
        m_last  = win;
        gq.push_back(win);
      end
    end
  end

  function automatic logic rdy_of(int n);
    return (n == 0) ? req0_ready : req1_ready;
  endfunction

  // Called just after a posedge. Returns just after the posedge that
  // completed the handshake, with valid still high.
  task automatic drive(int n, logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] exp);
    int k;
    k = 0;
    v[n]   = 1'b1;
    sop[n] = op;
    sa[n]  = a;
    sb[n]  = b;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy_of(n) && k < 2000);
    if (rdy_of(n)) begin
      if (n == 0) expq0.push_back(exp);
      else        expq1.push_back(exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL req%0d_grant_timeout: got no grant expected grant within 2000 cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_req(int n);
    v[n] = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(int n);
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    op = OW'($urandom % 16);
    a  = rand_word();
    b  = rand_word();
    drive(n, op, a, b, env_alu(op, a, b));
  endtask

  task automatic cycles(int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((expq0.size() != 0 || expq1.size() != 0 || busy) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_q0", expq0.size(), 0);
    chk("drain_q1", expq1.size(), 0);
  endtask

  int exp_seq[4];
  int seen;

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; sa[i] = '0; sb[i] = '0; sop[i] = '0; frdy[i] = 1'b1;
    end
    // Reset state, with both requests pending so ready gating is visible.
    cycles(2);
    v[0] = 1'b1;
    v[1] = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_resp0_valid", resp0_valid, 1'b0);
    chk("rst_resp1_valid", resp1_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_SrcA", alu_SrcA, 0);
    chk("rst_alu_SrcB", alu_SrcB, 0);
    chk("rst_alu_Operation", alu_Operation, 0);
    chk("rst_resp0_data", resp0_data, 0);
    v[0] = 1'b0;
    v[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single ADD 5+7 on requester 0.
    drive(0, 4'b0010, 32'd5, 32'd7, 32'd12);
    release_req(0);
    cycles(4);

    // Simultaneous SUB and SLT right after reset: requester 0 goes first.
    do_reset();
    gq.delete();
    fork
      begin drive(0, 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE); release_req(0); end
      begin drive(1, 4'b0111, 32'd3, 32'd5, 32'd1);         release_req(1); end
    join
    drain();
    if (gq.size() >= 2) begin
      chk("tie_first_grant", gq[0], 0);
      chk("tie_second_grant", gq[1], 1);
    end else begin
      checks++;
      errors++;
      $display("FAIL tie_grants: got %0d grants expected 2", gq.size());
    end

    // Both continuously valid, four operations each.
    do_reset();
    gq.delete();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    fork
      begin for (int i = 0; i < 4; i++) rand_op(0); release_req(0); end
      begin for (int j = 0; j < 4; j++) rand_op(1); release_req(1); end
    join
    drain();
    if (gq.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("grant_seq%0d", i), gq[i], exp_seq[i]);
    end else begin
      checks++;
      errors++;
      $display("FAIL grant_seq: got %0d grants expected at least 4", gq.size());
    end

    // Requester 1 withholds resp ready for several cycles while req0 waits.
    frdy[1] = 1'b0;
    cycles(1);
    drive(1, 4'b0010, 32'd100, 32'd23, 32'd123);
    release_req(1);
    fork
      begin drive(0, 4'b0001, 32'hF0, 32'h0F, 32'hFF); release_req(0); end
      begin
        int k;
        k = 0;
        while (!resp1_valid && k < 20) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        chk("hold_resp1_valid", resp1_valid, 1'b1);
        chk("hold_resp1_data", resp1_data, 32'd123);
        chk("hold_busy", busy, 1'b1);
        chk("hold_req0_ready", req0_ready, 1'b0);
        frdy[1] = 1'b1;
      end
    join
    drain();

    // Reset while the operation is in EXEC: it must vanish without a response.
    drive(0, 4'b0010, 32'd9, 32'd9, 32'd18);
    release_req(0);
    reset = 1'b1;
    @(negedge clk);
    chk("exec_rst_busy", busy, 1'b0);
    chk("exec_rst_resp0_valid", resp0_valid, 1'b0);
    chk("exec_rst_req0_ready", req0_ready, 1'b0);
    chk("exec_rst_alu_SrcA", alu_SrcA, 0);
    chk("exec_rst_alu_Operation", alu_Operation, 0);
    chk("exec_rst_resp0_data", resp0_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp0_valid) seen++;
    end
    chk("exec_rst_no_resp", seen, 0);

    // Randomized traffic with random response back-pressure.
    do_reset();
    rmode = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rand_op(0);
          release_req(0);
          cycles($urandom % 6);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          rand_op(1);
          release_req(1);
          cycles($urandom % 6);
        end
      end
    join
    rmode   = 1'b0;
    frdy[0] = 1'b1;
    frdy[1] = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
